// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode/funct3 constants, mem_stage state encoding and access helpers.
package riscv_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned LANES    = 4;

  localparam logic [OPCODE_W-1:0] OP_LOAD    = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE   = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH  = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_REG_REG = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_REG_IMM = 7'b0010011;

  localparam logic [FUNCT3_W-1:0] F3_LB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_LH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_LW  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_LBU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_LHU = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_SB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_SH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2,
    OUT    = 2'd3
  } mem_state_e;

  // Byte enables for an access of the size encoded in funct3 at the given lane.
  function automatic logic [LANES-1:0] be_mask(input logic [FUNCT3_W-1:0] f3,
                                               input logic [1:0] lane);
    logic [LANES-1:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << lane;
      2'b01:   m = 4'b0011 << lane;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // True when the access cannot be issued: bad alignment or an unsupported funct3.
  function automatic logic access_bad(input logic is_store,
                                      input logic [FUNCT3_W-1:0] f3,
                                      input logic [1:0] lane);
    logic bad;
    case (f3)
      F3_LB:   bad = 1'b0;
      F3_LH:   bad = lane[0];
      F3_LW:   bad = (lane != 2'b00);
      F3_LBU:  bad = is_store;
      F3_LHU:  bad = is_store | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-facing bundles on either side of the memory stage.
interface execute_memory_if #(parameter int unsigned N = 32);
  logic         valid;
  logic         ready;
  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [4:0]   rd;
  logic [N-1:0] alu_result;
  logic [N-1:0] store_data;

  modport ex  (output valid, opcode, funct3, rd, alu_result, store_data, input ready);
  modport mem (input valid, opcode, funct3, rd, alu_result, store_data, output ready);
endinterface

interface memory_writeback_if #(parameter int unsigned N = 32);
  logic         valid;
  logic         we;
  logic [4:0]   rd;
  logic [N-1:0] result;
  logic         ready;

  modport mem (output valid, we, rd, result, input ready);
  modport wb  (input valid, we, rd, result, output ready);
endinterface

// File: rtl/load_align.sv
// Extracts and extends the addressed byte/halfword/word from a read word.
module load_align
  import riscv_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [1:0]   lane,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] rdata,
  output logic [N-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Shift the selected lane down to bit 0, then extend according to funct3.
  always_comb begin
    byte_sel = 8'(rdata >> {lane, 3'b000});
    half_sel = 16'(rdata >> {lane, 3'b000});
    case (funct3)
      F3_LB:   result = {{(N-8){byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{(N-16){half_sel[15]}}, half_sel};
      F3_LBU:  result = {{(N-8){1'b0}}, byte_sel};
      F3_LHU:  result = {{(N-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores to dmem, aligns load data, hands results to writeback.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ex_valid,
  output logic         ex_ready,
  input  logic [6:0]   ex_opcode,
  input  logic [2:0]   ex_funct3,
  input  logic [4:0]   ex_rd,
  input  logic [N-1:0] ex_alu_result,
  input  logic [N-1:0] ex_store_data,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_wdata,
  output logic [3:0]   dmem_be,
  input  logic         dmem_gnt,
  input  logic         dmem_rvalid,
  input  logic [N-1:0] dmem_rdata,
  output logic         wb_valid,
  output logic         wb_we,
  output logic [4:0]   wb_rd,
  output logic [N-1:0] wb_result,
  input  logic         wb_ready,
  output logic         misaligned
);

  execute_memory_if   #(.N(N)) ex_bus ();
  memory_writeback_if #(.N(N)) wb_bus ();

  // Bind the flat pipeline ports onto the stage bundles.
  assign ex_bus.valid      = ex_valid;
  assign ex_bus.opcode     = ex_opcode;
  assign ex_bus.funct3     = ex_funct3;
  assign ex_bus.rd         = ex_rd;
  assign ex_bus.alu_result = ex_alu_result;
  assign ex_bus.store_data = ex_store_data;
  assign ex_bus.ready      = ex_ready;

  assign wb_bus.valid  = wb_valid;
  assign wb_bus.we     = wb_we;
  assign wb_bus.rd     = wb_rd;
  assign wb_bus.result = wb_result;
  assign wb_bus.ready  = wb_ready;

  mem_state_e   state;
  logic         is_store_q;
  logic [2:0]   f3_q;
  logic [1:0]   lane_q;
  logic [N-1:0] alu_q;

  logic         is_load_c;
  logic         is_store_c;
  logic         is_branch_c;
  logic         bad_c;
  logic [1:0]   lane_c;
  logic [N-1:0] wdata_c;
  logic [N-1:0] load_data_c;

  // Decode the incoming execute payload.
  always_comb begin
    lane_c      = ex_bus.alu_result[1:0];
    is_load_c   = (ex_bus.opcode == OP_LOAD);
    is_store_c  = (ex_bus.opcode == OP_STORE);
    is_branch_c = (ex_bus.opcode == OP_BRANCH);
    bad_c       = access_bad(is_store_c, ex_bus.funct3, lane_c);
    case (ex_bus.funct3[1:0])
      2'b00:   wdata_c = {(N/8){ex_bus.store_data[7:0]}};
      2'b01:   wdata_c = {(N/16){ex_bus.store_data[15:0]}};
      default: wdata_c = ex_bus.store_data;
    endcase
  end

  load_align #(.N(N)) u_load_align (
    .lane   (lane_q),
    .funct3 (f3_q),
    .rdata  (dmem_rdata),
    .result (load_data_c)
  );

  // Transaction FSM; one transaction in flight, every output registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ex_ready   <= 1'b1;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_result  <= '0;
      misaligned <= 1'b0;
      is_store_q <= 1'b0;
      f3_q       <= '0;
      lane_q     <= '0;
      alu_q      <= '0;
    end else begin
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_bus.valid && ex_ready) begin
            ex_ready   <= 1'b0;
            wb_rd      <= ex_bus.rd;
            f3_q       <= ex_bus.funct3;
            lane_q     <= lane_c;
            alu_q      <= ex_bus.alu_result;
            is_store_q <= is_store_c;
            if ((is_load_c || is_store_c) && bad_c) begin
              misaligned <= 1'b1;
              state      <= OUT;
              wb_valid   <= 1'b1;
              wb_we      <= 1'b0;
              wb_result  <= ex_bus.alu_result;
            end else if (is_load_c || is_store_c) begin
              state      <= REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store_c;
              dmem_addr  <= {ex_bus.alu_result[N-1:2], 2'b00};
              dmem_be    <= be_mask(ex_bus.funct3, lane_c);
              dmem_wdata <= is_store_c ? wdata_c : '0;
            end else begin
              state     <= OUT;
              wb_valid  <= 1'b1;
              wb_we     <= !(is_store_c || is_branch_c);
              wb_result <= ex_bus.alu_result;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= '0;
            if (is_store_q) begin
              state     <= OUT;
              wb_valid  <= 1'b1;
              wb_we     <= 1'b0;
              wb_result <= alu_q;
            end else if (dmem_rvalid) begin
              state     <= OUT;
              wb_valid  <= 1'b1;
              wb_we     <= 1'b1;
              wb_result <= load_data_c;
            end else begin
              state <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          if (dmem_rvalid) begin
            state     <= OUT;
            wb_valid  <= 1'b1;
            wb_we     <= 1'b1;
            wb_result <= load_data_c;
          end
        end
        OUT: begin
          if (wb_bus.ready) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            ex_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter N, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ex_valid  input  1  execute stage presents a result.
REQ-005 SHALL have port ex_ready  output  1  mem_stage accepts ex_* this cycle.
REQ-006 SHALL have port ex_opcode  input  7  riscv_pkg opcode.
REQ-007 SHALL have port ex_funct3  input  3  access size/sign.
REQ-008 SHALL have port ex_rd  input  5  destination register.
REQ-009 SHALL have port ex_alu_result  input  N  ALU result / effective address.
REQ-010 SHALL have port ex_store_data  input  N  rs2 value for stores.
REQ-011 SHALL have ports dmem_req/dmem_we  output  1/1  memory request, write enable.
REQ-012 SHALL have ports dmem_addr/dmem_wdata/dmem_be  output  N/N/4  word-aligned address, lane-shifted data, byte enables.
REQ-013 SHALL have ports dmem_gnt/dmem_rvalid  input  1/1  request accepted, read data valid.
REQ-014 SHALL have port dmem_rdata  input  N  read word.
REQ-015 SHALL have ports wb_valid/wb_we/wb_rd/wb_result  output  1/1/5/N  writeback payload.
REQ-016 SHALL have port wb_ready  input  1  writeback accepts payload.
REQ-017 SHALL have port misaligned  output  1  one-cycle pulse on misaligned access.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, RDWAIT, OUT.
REQ-019 SHALL assert ex_ready only in IDLE; transfer occurs when ex_valid && ex_ready at clock edge, capturing all ex_* into registers.
REQ-020 Non-memory opcode (REG_REG, REG_IMM, others): IDLE->OUT, wb_result=alu_result, wb_we=1 unless opcode is STORE/BRANCH, latency 1 cycle to wb_valid.
REQ-021 LOAD/STORE: IDLE->REQ; dmem_req held high in REQ with stable addr/we/be/wdata until dmem_gnt.
REQ-022 STORE on gnt: REQ->OUT, wb_we=0; LOAD on gnt: REQ->RDWAIT; gnt and rvalid in same cycle SHALL go directly to OUT.
REQ-023 RDWAIT->OUT on dmem_rvalid, capturing extracted load data.
REQ-024 dmem_addr SHALL be {alu_result[N-1:2],2'b00}; byte lane = alu_result[1:0].
REQ-025 Store be: SB 0001<<lane, SH 0011<<lane, SW 1111; wdata replicated byte/half across lanes.
REQ-026 Load extraction: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word, from selected lane.
REQ-027 Misaligned (halfword lane odd, word lane != 0): no dmem_req, misaligned pulses 1 cycle, IDLE->OUT with wb_we=0, wb_result=alu_result.
REQ-028 In OUT wb_valid=1 with payload stable until wb_ready; on wb_ready OUT->IDLE; no new acceptance in the same cycle (one transaction in flight).
REQ-029 Unknown funct3 on LOAD/STORE SHALL be treated as misaligned.

Reset
REQ-030 rst SHALL force IDLE and drive ex_ready=1(after IDLE), dmem_req=0, dmem_we=0, dmem_be=0, wb_valid=0, wb_we=0, misaligned=0, wb_result=0, wb_rd=0.
REQ-031 rst mid-transaction (REQ/RDWAIT/OUT) SHALL abandon it; a later dmem_rvalid in IDLE SHALL be ignored.

Structure
REQ-032 Opcode and funct3 load/store constants (F3_LB..F3_SW) and the state enum SHALL reside in riscv_pkg.
REQ-033 Load extraction SHALL be a combinational sub-module load_align (lane, funct3, rdata -> result).
REQ-034 SHALL connect to the pipeline via execute_memory_if and a memory_writeback_if modport at top level.

Verification
REQ-035 ADD result 0x00000008, rd=5 -> wb_valid next cycle, wb_result=0x00000008, wb_we=1, no dmem_req.
REQ-036 SB addr 0x00001001 data 0x000000AB -> dmem_addr 0x00001000, be 0010, wdata 0xABABABAB, wb_we=0.
REQ-037 LB addr 0x00001003, rdata 0x80FFFFFF, gnt delayed 2 cycles, rvalid 1 later -> wb_result 0xFFFFFF80; LBU -> 0x00000080.
REQ-038 LW addr 0x00002002 -> misaligned pulse, no dmem_req, wb_we=0.
REQ-039 wb_ready low 3 cycles in OUT -> payload stable, ex_ready=0 throughout.
REQ-040 rst asserted in RDWAIT then rvalid -> outputs at reset values, no wb_valid.
